// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit with architectural HI/LO
//               registers. MULT/MULTU use shift-add, DIV/DIVU use restoring
//               shift-subtract, one bit per cycle, then a single sign-fix
//               cycle. MTHI/MTLO write HI/LO directly.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              c_CNT_W  = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_count;
    logic               r_isdiv;
    logic               r_sa;
    logic               r_sb;
    logic               r_bzero;
    logic [WIDTH-1:0]   r_m;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_ph;    // product high half / partial remainder
    logic [WIDTH-1:0]   r_pl;    // product low half / dividend-quotient shifter
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_divzero;

    // Command decode; start only matters in IDLE
    logic             w_accept;
    logic             w_iter;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_signed;
    logic             w_nega;
    logic             w_negb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_accept = start && (r_state == c_S_IDLE);
    assign w_iter   = w_accept && !command[2];
    assign w_mthi   = w_accept && (command == 3'b100);
    assign w_mtlo   = w_accept && (command == 3'b101);
    assign w_signed = !command[0];
    assign w_nega   = w_signed && operandA[WIDTH-1];
    assign w_negb   = w_signed && operandB[WIDTH-1];
    assign w_abs_a  = w_nega ? (~operandA + 1'b1) : operandA;
    assign w_abs_b  = w_negb ? (~operandB + 1'b1) : operandB;

    // One multiply step: conditionally add multiplicand, shift pair right
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    // One restoring divide step: shift in next dividend bit, try subtract.
    // A zero divisor always "fits", so the quotient becomes all ones and the
    // remainder register ends up holding the dividend magnitude unchanged.
    logic [WIDTH:0]   w_rem_sh;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_sub;
    assign w_rem_sh  = {r_ph, r_pl[WIDTH-1]};
    assign w_qbit    = (w_rem_sh >= {1'b0, r_m});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_m;

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    assign w_prod     = {r_ph, r_pl};
    assign w_prod_fix = (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fix  = (r_sa ^ r_sb) ? (~r_pl + 1'b1) : r_pl;
    assign w_rem_fix  = r_sa ? (~r_ph + 1'b1) : r_ph;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> RUN (WIDTH cycles) -> FIX -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: if (w_iter) w_next_state = c_S_RUN;
            c_S_RUN:  if (r_count == c_CNT_LAST) w_next_state = c_S_FIX;
            c_S_FIX:  w_next_state = c_S_IDLE;
            default:  w_next_state = c_S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, result and HI/LO writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_isdiv   <= 1'b0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_bzero   <= 1'b0;
            r_m       <= '0;
            r_ph      <= '0;
            r_pl      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_iter) begin
                        r_isdiv <= command[1];
                        r_sa    <= w_nega;
                        r_sb    <= w_negb;
                        r_bzero <= command[1] && (operandB == '0);
                        r_m     <= command[1] ? w_abs_b : w_abs_a;
                        r_pl    <= command[1] ? w_abs_a : w_abs_b;
                        r_ph    <= '0;
                        r_count <= c_CNT_INIT;
                    end
                    if (w_mthi) begin
                        r_hi      <= operandA;
                        r_done    <= 1'b1;
                        r_divzero <= 1'b0;
                    end
                    if (w_mtlo) begin
                        r_lo      <= operandA;
                        r_done    <= 1'b1;
                        r_divzero <= 1'b0;
                    end
                end
                c_S_RUN: begin
                    r_count <= r_count - 1'b1;
                    if (r_isdiv) begin
                        r_ph <= w_qbit ? w_rem_sub : w_rem_sh[WIDTH-1:0];
                        r_pl <= {r_pl[WIDTH-2:0], w_qbit};
                    end else begin
                        r_ph <= w_sum[WIDTH:1];
                        r_pl <= {w_sum[0], r_pl[WIDTH-1:1]};
                    end
                end
                c_S_FIX: begin
                    r_done <= 1'b1;
                    if (!r_isdiv) begin
                        r_hi      <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo      <= w_prod_fix[WIDTH-1:0];
                        r_divzero <= 1'b0;
                    end else if (r_bzero) begin
                        // Restore the original dividend bit pattern into HI
                        r_hi      <= w_rem_fix;
                        r_lo      <= '1;
                        r_divzero <= 1'b1;
                    end else begin
                        r_hi      <= w_rem_fix;
                        r_lo      <= w_quo_fix;
                        r_divzero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != c_S_IDLE);
    assign done    = r_done;
    assign divzero = r_divzero;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit; random and directed
//               operations compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   command;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic         busy;
    logic         done;
    logic         divzero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_total = 0;
    int n_bad   = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic         m_dz;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .command  (command),
        .operandA (operandA),
        .operandB (operandB),
        .busy     (busy),
        .done     (done),
        .divzero  (divzero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one command, from plain arithmetic
    task automatic model(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (cmd)
            3'b000: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0; end
            3'b001: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; m_dz = 1'b0; end
            3'b010, 3'b011: begin
                if (b == '0) begin
                    m_hi = a; m_lo = '1; m_dz = 1'b1;
                end else if (cmd == 3'b010) begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0]; m_dz = 1'b0;
                end else begin
                    uq = ua / ub; ur = ua % ub;
                    m_lo = uq[31:0]; m_hi = ur[31:0]; m_dz = 1'b0;
                end
            end
            3'b100: begin m_hi = a; m_dz = 1'b0; end
            3'b101: begin m_lo = a; m_dz = 1'b0; end
            default: ;
        endcase
    endtask

    // Issue one command at the current cycle and follow it to done
    task automatic do_op(input string tag, input logic [2:0] cmd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int poke_at);
        logic [W-1:0] ph, pl;
        int           c, busy_cnt;
        bit           changed, iter;
        iter = (cmd[2] == 1'b0);
        ph = m_hi;
        pl = m_lo;
        command = cmd; operandA = a; operandB = b; start = 1'b1;
        tick();
        start = 1'b0;
        command = 3'($urandom); operandA = $urandom; operandB = $urandom;
        model(cmd, a, b);
        c = 0; busy_cnt = 0; changed = 1'b0;
        while (!done && c < W + 8) begin
            if (busy) busy_cnt++;
            if (hi !== ph || lo !== pl) changed = 1'b1;
            if (c == poke_at) begin
                start = 1'b1; command = 3'b011; operandA = $urandom; operandB = $urandom;
            end
            if (c == poke_at + 1) start = 1'b0;
            tick();
            c++;
        end
        check_eq({tag, ":lat"}, c, iter ? W + 1 : 0);
        check_eq({tag, ":busy"}, busy_cnt, iter ? W + 1 : 0);
        if (iter) check_eq({tag, ":stable"}, changed, 0);
        check_eq({tag, ":hi"}, hi, m_hi);
        check_eq({tag, ":lo"}, lo, m_lo);
        check_eq({tag, ":dz"}, divzero, m_dz);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; command = 3'b000; operandA = '0; operandB = '0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        tick();
        tick();
        check_eq("rst:hi", hi, 0);
        check_eq("rst:lo", lo, 0);
        check_eq("rst:busy", busy, 0);
        check_eq("rst:done", done, 0);
        check_eq("rst:dz", divzero, 0);
        reset = 1'b0;
        tick();

        do_op("mult", 3'b000, 32'hFFFF_FFFD, 32'h0000_0005, -1);
        check_eq("mult:spec_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult:spec_lo", lo, 32'hFFFF_FFF1);
        tick();
        check_eq("mult:pulse", done, 0);
        do_op("multu", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check_eq("multu:spec_hi", hi, 32'hFFFF_FFFE);
        do_op("div", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, -1);
        check_eq("div:spec_lo", lo, 32'hFFFF_FFFD);
        do_op("divu", 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, -1);
        check_eq("divu:spec_lo", lo, 32'h7FFF_FFFC);
        do_op("divu0", 3'b011, 32'h0000_0007, 32'h0000_0000, -1);
        check_eq("divu0:spec_dz", divzero, 1);

        // No-op command: nothing changes, divzero holds
        command = 3'b110; operandA = $urandom; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("noop:done", done, 0);
        check_eq("noop:busy", busy, 0);
        check_eq("noop:hi", hi, m_hi);
        check_eq("noop:lo", lo, m_lo);
        tick();
        check_eq("noop:dz", divzero, 1);

        do_op("div0s", 3'b010, 32'h8000_0000, 32'h0000_0000, -1);
        do_op("divovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check_eq("divovf:spec_lo", lo, 32'h8000_0000);

        do_op("mthi", 3'b100, 32'h1234_5678, 32'h0, -1);
        do_op("mtlo", 3'b101, 32'h9ABC_DEF0, 32'h0, -1);
        tick();
        check_eq("mt:pulse", done, 0);
        check_eq("mt:hi", hi, 32'h1234_5678);

        // Start re-pulsed while busy must be ignored
        do_op("ignore", 3'b000, 32'h0001_2345, 32'hFFFF_0003, 5);
        tick();
        check_eq("ignore:idle", busy, 0);

        // Reset mid-operation aborts and clears HI/LO
        command = 3'b000; operandA = 32'h7777_7777; operandB = 32'h3333_3333; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        check_eq("abort:hi", hi, 0);
        check_eq("abort:lo", lo, 0);
        check_eq("abort:busy", busy, 0);
        check_eq("abort:done", done, 0);
        do_op("fresh", 3'b000, 32'h0000_0010, 32'hFFFF_FFF0, -1);

        // Random back-to-back traffic
        for (int i = 0; i < 150; i++) begin
            do_op("rnd", 3'($urandom_range(0, 5)), pick(), pick(), -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
